// File: rtl/ts_pkg.sv
// Shared constants, FSM state type and null-packet byte generator for the
// TS output multiplexer.
package ts_pkg;

  localparam int unsigned TS_PKT_LEN      = 188;
  localparam logic [7:0]  TS_SYNC         = 8'h47;
  localparam logic [12:0] NULL_PID        = 13'h1FFF;
  localparam logic [7:0]  TS_PAYLOAD_ONLY = 8'h10;
  localparam logic [7:0]  NULL_FILL       = 8'hFF;
  localparam logic [7:0]  LAST_BYTE       = 8'(TS_PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_SEL,
    ST_SEND,
    ST_NULL
  } state_t;

  // Header is sync, PID 0x1FFF with all flags clear, payload-only with CC=0.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    null_byte = TS_SYNC;
      8'd1:    null_byte = {3'b000, NULL_PID[12:8]};
      8'd2:    null_byte = NULL_PID[7:0];
      8'd3:    null_byte = TS_PAYLOAD_ONLY;
      default: null_byte = NULL_FILL;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index above rr_last,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] rr_last,
  output logic [W-1:0] grant,
  output logic         any
);

  int unsigned idx;
  logic [N-1:0] shifted;

  always_comb begin
    grant   = '0;
    any     = 1'b0;
    idx     = 0;
    shifted = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx     = (32'(rr_last) + i) % N;
      shifted = elig >> idx;
      if (!any && shifted[0]) begin
        grant = W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts_mux_scheduler.sv
// Packet-granular round-robin TS multiplexer: forwards 188-byte packets from
// N_CH channel buffers onto one TS port, filling idle slots with null packets.
module ts_mux_scheduler
  import ts_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter bit          NULL_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   REQ,
  input  logic [N_CH-1:0]   CH_MASK,
  input  logic [8*N_CH-1:0] RD_DATA,
  output logic [N_CH-1:0]   RD_EN,
  output logic [7:0]        DATA,
  output logic              D_CLK,
  output logic              D_VALID,
  output logic              P_SYNC,
  output logic [CH_W-1:0]   CH_ACTIVE,
  output logic              NULL_ACTIVE,
  output logic              SYNC_ERR
);

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [CH_W-1:0] grant_q, grant_nxt;
  logic [CH_W-1:0] rr_last, rr_last_nxt;
  logic [CH_W-1:0] arb_grant;
  logic            arb_any;
  logic            issue, issue_null;

  logic            s1_valid, s1_null;
  logic [CH_W-1:0] s1_ch;
  logic [7:0]      s1_idx;
  logic [7:0]      rd_byte, s1_byte;

  assign D_CLK = CLK;

  rr_arbiter #(
    .N(N_CH),
    .W(CH_W)
  ) u_arb (
    .elig   (REQ & CH_MASK),
    .rr_last(rr_last),
    .grant  (arb_grant),
    .any    (arb_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_SEL;
      cnt     <= '0;
      grant_q <= '0;
      rr_last <= CH_W'(N_CH - 1);
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      grant_q <= grant_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    grant_nxt   = grant_q;
    rr_last_nxt = rr_last;
    issue       = 1'b0;
    issue_null  = 1'b0;
    case (state)
      ST_SEL: begin
        cnt_nxt = '0;
        if (arb_any) begin
          state_nxt   = ST_SEND;
          grant_nxt   = arb_grant;
          rr_last_nxt = arb_grant;
        end else if (NULL_EN) begin
          state_nxt = ST_NULL;
        end
      end
      ST_SEND, ST_NULL: begin
        issue      = 1'b1;
        issue_null = (state == ST_NULL);
        if (cnt == LAST_BYTE) begin
          state_nxt = ST_SEL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ST_SEL;
    endcase
  end

  assign RD_EN = (issue && !issue_null) ? (N_CH'(1) << grant_q) : '0;

  // Stage 1 tracks the byte whose buffer data is on RD_DATA this cycle, so the
  // null path is generated in the same slot and both paths share one latency.
  assign rd_byte = 8'(RD_DATA >> (32'(s1_ch) * 8));
  assign s1_byte = s1_null ? null_byte(s1_idx) : rd_byte;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid    <= 1'b0;
      s1_null     <= 1'b0;
      s1_ch       <= '0;
      s1_idx      <= '0;
      DATA        <= '0;
      D_VALID     <= 1'b0;
      P_SYNC      <= 1'b0;
      CH_ACTIVE   <= '0;
      NULL_ACTIVE <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      s1_valid    <= issue;
      s1_null     <= issue_null;
      s1_ch       <= grant_q;
      s1_idx      <= cnt;
      D_VALID     <= s1_valid;
      P_SYNC      <= s1_valid && (s1_idx == '0);
      NULL_ACTIVE <= s1_valid && s1_null;
      SYNC_ERR    <= s1_valid && !s1_null && (s1_idx == '0) && (rd_byte != TS_SYNC);
      if (s1_valid) begin
        DATA <= s1_byte;
      end
      if (s1_valid && !s1_null) begin
        CH_ACTIVE <= s1_ch;
      end
    end
  end

endmodule

// File: doc/ts_mux_scheduler.md
Name: ts_mux_scheduler

Overview:
- Packet-granular scheduler that shares one TS output port between N_CH tuner-channel packet buffers.
- At each packet boundary it picks one requesting channel round-robin, reads exactly 188 bytes from that channel's buffer, and forwards them.
- If no channel is eligible, it emits a null packet (PID 0x1FFF).
- Sits between the per-channel packet FIFOs and the TS output interface (DATA/D_CLK/D_VALID/P_SYNC).

Parameters:
- N_CH, 4, number of source channels (2..8)
- CH_W, 2, width of the channel index; must equal clog2(N_CH)
- NULL_EN, 1, 1 = insert null packets when idle; 0 = hold D_VALID low instead

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- REQ  in  N_CH  per-channel "full 188-byte packet available" flag
- CH_MASK  in  N_CH  per-channel enable; 0 = never granted
- RD_DATA  in  8*N_CH  per-channel read data; channel i on bits [8i+7:8i]; valid 1 cycle after RD_EN[i]
- RD_EN  out  N_CH  one-hot read strobe to the granted channel buffer
- DATA  out  8  output TS byte
- D_CLK  out  1  output byte clock, equal to CLK
- D_VALID  out  1  DATA qualifier
- P_SYNC  out  1  high on byte 0 of every output packet
- CH_ACTIVE  out  CH_W  index of the channel currently being sent
- NULL_ACTIVE  out  1  high while a null packet is being sent
- SYNC_ERR  out  1  1-cycle pulse when a forwarded byte 0 is not 0x47

Behaviour:
- Clock, reset and D_CLK
  - Single clock CLK.
  - RST is synchronous and active-high.
  - D_CLK is combinationally CLK.
- Reset values
  - RD_EN=0, DATA=0, D_VALID=0, P_SYNC=0, CH_ACTIVE=0, NULL_ACTIVE=0, SYNC_ERR=0.
  - FSM=SEL, byte counter=0.
  - rr_last=N_CH-1, so channel 0 has first priority.
- FSM states: SEL, SEND, NULL.
  - SEL (1 cycle): elig = REQ & CH_MASK.
    - elig≠0: grant the first set bit searching upward from rr_last+1 modulo N_CH; rr_last<=grant; -> SEND.
    - elig=0 and NULL_EN=1: -> NULL.
    - elig=0 and NULL_EN=0: stay in SEL.
  - SEND: RD_EN[grant]=1 for exactly 188 consecutive cycles; byte counter 0..187; at 187 -> SEL.
  - NULL: 188 cycles generating null bytes; at 187 -> SEL. rr_last is unchanged.
- REQ and CH_MASK are sampled only in SEL.
  - REQ deassertion during SEND is ignored; sources guarantee a full packet when REQ=1.
  - CH_MASK changes take effect at the next SEL.
- Pipeline: fixed 2-cycle latency from byte-issue cycle to output, identical for SEND and NULL.
  - Cycle t: RD_EN (or null byte index) issued for byte k.
  - Cycle t+1: RD_DATA valid; the null byte is generated from the stage-1 counter.
  - Cycle t+2: DATA registered; D_VALID=1; P_SYNC=(k==0).
- Null packet contents: bytes 0x47, 0x1F, 0xFF, 0x10, then 0xFF×184. CC is fixed at 0.
- Output timing
  - D_VALID is low for exactly 1 cycle between packets, because of the SEL cycle.
  - D_VALID stays low continuously while idle with NULL_EN=0.
- CH_ACTIVE / NULL_ACTIVE are aligned with DATA (delayed 2 cycles) and held for all 188 output bytes.
- SYNC_ERR: pulses in the same cycle as a P_SYNC=1 byte if forwarded DATA≠0x47. Data is still forwarded unchanged.
- Reset mid-packet
  - Takes effect on the next edge: the pipeline is flushed and no partial packet completes.
  - The first post-reset packet starts with SEL.

Decomposition:
- Package ts_pkg:
  - TS_PKT_LEN=188, TS_SYNC=8'h47, NULL_PID=13'h1FFF, TS_PAYLOAD_ONLY=8'h10, NULL_FILL=8'hFF.
  - FSM state typedef {SEL, SEND, NULL}.
- Sub-module rr_arbiter: parameter N; inputs elig and rr_last; outputs grant index and any. Purely combinational, instantiated once.

Test Plan:
- Single channel: REQ=4'b0001, CH_MASK=4'hF, RD_DATA0 = 47,01,00,10,… -> 188 RD_EN[0] pulses; DATA matches 2 cycles later; P_SYNC on 0x47; 1-cycle D_VALID gap; CH_ACTIVE=0.
- Round-robin: REQ=4'hF held -> output packet order 0,1,2,3,0,…; exactly 188 RD_EN per grant; never two RD_EN bits high.
- Idle: REQ=0 with NULL_EN=1 -> packets 47,1F,FF,10,FF… with NULL_ACTIVE=1. With NULL_EN=0 -> D_VALID stays 0 and RD_EN stays 0.
- Mask and late REQ: CH_MASK=4'b1010, REQ=4'hF -> only channels 1 and 3 are granted. REQ[2] rising mid-packet -> channel 2 is not served until the next SEL.
- Sync error: channel 2 byte 0 = 0x46 -> SYNC_ERR 1-cycle pulse aligned with P_SYNC; byte is still forwarded.
- Reset at byte 100 of a SEND -> next cycle all outputs 0; channel 0 has first priority afterwards; no partial tail appears after reset.
